// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_sequencer
//  Description : Arbitrates fetch / load / store / swap / exception memory
//                requests and sequences the address mux, write enable,
//                write-data mux and capture strobes for one shared memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
  parameter int RD_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       load_req,
  input  logic       store_req,
  input  logic       ls_direct,
  input  logic       swap_req,
  input  logic       exc_req,
  output logic [2:0] iord_sel,
  output logic       mem_wr,
  output logic [1:0] wdata_sel,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       tmp_a_load,
  output logic       tmp_b_load,
  output logic [2:0] op,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_SW_RD1 = 3'd3,
    S_SW_RD2 = 3'd4,
    S_SW_WR1 = 3'd5,
    S_SW_WR2 = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [2:0] c_op_none  = 3'b000;
  localparam logic [2:0] c_op_fetch = 3'b001;
  localparam logic [2:0] c_op_load  = 3'b010;
  localparam logic [2:0] c_op_store = 3'b011;
  localparam logic [2:0] c_op_swap  = 3'b100;
  localparam logic [2:0] c_op_exc   = 3'b101;

  localparam logic [2:0] c_ad_pc     = 3'b000;
  localparam logic [2:0] c_ad_exc    = 3'b001;
  localparam logic [2:0] c_ad_aluout = 3'b010;
  localparam logic [2:0] c_ad_alures = 3'b011;
  localparam logic [2:0] c_ad_swap1  = 3'b100;
  localparam logic [2:0] c_ad_swap2  = 3'b101;

  localparam logic [1:0] c_wd_regb  = 2'b00;
  localparam logic [1:0] c_wd_tmp_a = 2'b01;
  localparam logic [1:0] c_wd_tmp_b = 2'b10;

  // Last wait-count value of a read phase; a read phase lasts RD_WAIT+1 cycles.
  localparam logic [2:0] c_rd_last = 3'(RD_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic       ls_direct_q, ls_direct_d;

  logic [2:0] iord_sel_q, iord_sel_d;
  logic       mem_wr_q, mem_wr_d;
  logic [1:0] wdata_sel_q, wdata_sel_d;
  logic       ir_load_q, ir_load_d;
  logic       mdr_load_q, mdr_load_d;
  logic       tmp_a_load_q, tmp_a_load_d;
  logic       tmp_b_load_q, tmp_b_load_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       rd_last_d;

  // Next state, wait counter and latched request; arbitration only in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ls_direct_d = ls_direct_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        op_d  = c_op_none;
        if (exc_req) begin
          op_d    = c_op_exc;
          state_d = S_RD;
        end else if (swap_req) begin
          op_d    = c_op_swap;
          state_d = S_SW_RD1;
        end else if (store_req) begin
          op_d        = c_op_store;
          ls_direct_d = ls_direct;
          state_d     = S_WR;
        end else if (load_req) begin
          op_d        = c_op_load;
          ls_direct_d = ls_direct;
          state_d     = S_RD;
        end else if (fetch_req) begin
          op_d    = c_op_fetch;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == c_rd_last) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_SW_RD1: begin
        if (cnt_q == c_rd_last) begin
          cnt_d   = 3'd0;
          state_d = S_SW_RD2;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_SW_RD2: begin
        if (cnt_q == c_rd_last) begin
          cnt_d   = 3'd0;
          state_d = S_SW_WR1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR:     state_d = S_DONE;
      S_SW_WR1: state_d = S_SW_WR2;
      S_SW_WR2: state_d = S_DONE;
      S_DONE: begin
        op_d    = c_op_none;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 3'd0;
        op_d    = c_op_none;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  // without adding a cycle of latency.
  always_comb begin
    iord_sel_d   = c_ad_pc;
    mem_wr_d     = 1'b0;
    wdata_sel_d  = c_wd_regb;
    ir_load_d    = 1'b0;
    mdr_load_d   = 1'b0;
    tmp_a_load_d = 1'b0;
    tmp_b_load_d = 1'b0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    rd_last_d    = (cnt_d == c_rd_last);
    case (state_d)
      S_RD: begin
        if (op_d == c_op_exc) begin
          iord_sel_d = c_ad_exc;
        end else if (op_d == c_op_load) begin
          iord_sel_d = ls_direct_d ? c_ad_alures : c_ad_aluout;
        end else begin
          iord_sel_d = c_ad_pc;
        end
        if (rd_last_d) begin
          ir_load_d  = (op_d == c_op_fetch);
          mdr_load_d = (op_d != c_op_fetch);
        end
      end
      S_WR: begin
        iord_sel_d  = ls_direct_d ? c_ad_alures : c_ad_aluout;
        mem_wr_d    = 1'b1;
        wdata_sel_d = c_wd_regb;
      end
      S_SW_RD1: begin
        iord_sel_d   = c_ad_swap1;
        tmp_a_load_d = rd_last_d;
      end
      S_SW_RD2: begin
        iord_sel_d   = c_ad_swap2;
        tmp_b_load_d = rd_last_d;
      end
      S_SW_WR1: begin
        iord_sel_d  = c_ad_swap1;
        mem_wr_d    = 1'b1;
        wdata_sel_d = c_wd_tmp_b;
      end
      S_SW_WR2: begin
        iord_sel_d  = c_ad_swap2;
        mem_wr_d    = 1'b1;
        wdata_sel_d = c_wd_tmp_a;
      end
      default: begin
        iord_sel_d = c_ad_pc;
      end
    endcase
  end

  // State and registered outputs; reset aborts any op, including a swap write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      op_q         <= c_op_none;
      ls_direct_q  <= 1'b0;
      iord_sel_q   <= c_ad_pc;
      mem_wr_q     <= 1'b0;
      wdata_sel_q  <= c_wd_regb;
      ir_load_q    <= 1'b0;
      mdr_load_q   <= 1'b0;
      tmp_a_load_q <= 1'b0;
      tmp_b_load_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      ls_direct_q  <= ls_direct_d;
      iord_sel_q   <= iord_sel_d;
      mem_wr_q     <= mem_wr_d;
      wdata_sel_q  <= wdata_sel_d;
      ir_load_q    <= ir_load_d;
      mdr_load_q   <= mdr_load_d;
      tmp_a_load_q <= tmp_a_load_d;
      tmp_b_load_q <= tmp_b_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign iord_sel   = iord_sel_q;
  assign mem_wr     = mem_wr_q;
  assign wdata_sel  = wdata_sel_q;
  assign ir_load    = ir_load_q;
  assign mdr_load   = mdr_load_q;
  assign tmp_a_load = tmp_a_load_q;
  assign tmp_b_load = tmp_b_load_q;
  assign op         = op_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_sequencer
//  Description : Self-checking bench: transaction-level schedule model for the
//                RD_WAIT=1 instance plus literal timing checks on RD_WAIT=0/1/7.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

  localparam int W_MAIN = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0;
  logic ls_direct = 1'b0, swap_req = 1'b0, exc_req = 1'b0;

  logic [2:0] iord_sel, op;
  logic [1:0] wdata_sel;
  logic       mem_wr, ir_load, mdr_load, tmp_a_load, tmp_b_load, busy, done;

  logic       f0 = 1'b0;
  logic [2:0] w0_iord, w0_op;
  logic [1:0] w0_wd;
  logic       w0_wr, w0_ir, w0_mdr, w0_ta, w0_tb, w0_busy, w0_done;

  logic       f7 = 1'b0, l7 = 1'b0;
  logic [2:0] w7_iord, w7_op;
  logic [1:0] w7_wd;
  logic       w7_wr, w7_ir, w7_mdr, w7_ta, w7_tb, w7_busy, w7_done;

  always #5 clk = ~clk;

  mem_access_sequencer #(.RD_WAIT(W_MAIN)) u_dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .load_req(load_req),
    .store_req(store_req), .ls_direct(ls_direct), .swap_req(swap_req), .exc_req(exc_req),
    .iord_sel(iord_sel), .mem_wr(mem_wr), .wdata_sel(wdata_sel), .ir_load(ir_load),
    .mdr_load(mdr_load), .tmp_a_load(tmp_a_load), .tmp_b_load(tmp_b_load),
    .op(op), .busy(busy), .done(done)
  );

  mem_access_sequencer #(.RD_WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .fetch_req(f0), .load_req(1'b0),
    .store_req(1'b0), .ls_direct(1'b0), .swap_req(1'b0), .exc_req(1'b0),
    .iord_sel(w0_iord), .mem_wr(w0_wr), .wdata_sel(w0_wd), .ir_load(w0_ir),
    .mdr_load(w0_mdr), .tmp_a_load(w0_ta), .tmp_b_load(w0_tb),
    .op(w0_op), .busy(w0_busy), .done(w0_done)
  );

  mem_access_sequencer #(.RD_WAIT(7)) u_w7 (
    .clk(clk), .reset(reset), .fetch_req(f7), .load_req(l7),
    .store_req(1'b0), .ls_direct(1'b0), .swap_req(1'b0), .exc_req(1'b0),
    .iord_sel(w7_iord), .mem_wr(w7_wr), .wdata_sel(w7_wd), .ir_load(w7_ir),
    .mdr_load(w7_mdr), .tmp_a_load(w7_ta), .tmp_b_load(w7_tb),
    .op(w7_op), .busy(w7_busy), .done(w7_done)
  );

  // Packed view: {op, iord, wdata, wr, ir, mdr, ta, tb, busy, done, 0}
  logic [15:0] act;
  assign act = {op, iord_sel, wdata_sel, mem_wr, ir_load, mdr_load,
                tmp_a_load, tmp_b_load, busy, done, 1'b0};

  function automatic logic [15:0] mk(input logic [2:0] o, input logic [2:0] ad,
                                     input logic [1:0] wd, input logic wr,
                                     input logic [3:0] stb, input logic dn);
    return {o, ad, wd, wr, stb, 1'b1, dn, 1'b0};
  endfunction

  // ---------------- behavioural model (RD_WAIT = W_MAIN) ----------------
  // On acceptance the whole per-cycle output schedule of the transaction is
  // queued; each clock edge consumes one entry. An empty queue means IDLE.
  logic [15:0] q[$];
  logic [15:0] cur = '0;
  int          cyc = 0;

  task automatic push_read(input logic [2:0] o, input logic [2:0] ad, input logic [3:0] stb);
    for (int i = 0; i <= W_MAIN; i++)
      q.push_back(mk(o, ad, 2'b00, 1'b0, (i == W_MAIN) ? stb : 4'b0000, 1'b0));
    q.push_back(mk(o, 3'b000, 2'b00, 1'b0, 4'b0000, 1'b1));
  endtask

  task automatic push_swap();
    for (int i = 0; i <= W_MAIN; i++)
      q.push_back(mk(3'b100, 3'b100, 2'b00, 1'b0, (i == W_MAIN) ? 4'b0010 : 4'b0000, 1'b0));
    for (int i = 0; i <= W_MAIN; i++)
      q.push_back(mk(3'b100, 3'b101, 2'b00, 1'b0, (i == W_MAIN) ? 4'b0001 : 4'b0000, 1'b0));
    q.push_back(mk(3'b100, 3'b100, 2'b10, 1'b1, 4'b0000, 1'b0));
    q.push_back(mk(3'b100, 3'b101, 2'b01, 1'b1, 4'b0000, 1'b0));
    q.push_back(mk(3'b100, 3'b000, 2'b00, 1'b0, 4'b0000, 1'b1));
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      q.delete();
      cur <= '0;
    end else if (q.size() > 0) begin
      cur <= q.pop_front();
    end else if (cur[2] == 1'b0) begin
      // previous cycle was IDLE: arbitrate
      if (exc_req)        push_read(3'b101, 3'b001, 4'b0100);
      else if (swap_req)  push_swap();
      else if (store_req) begin
        q.push_back(mk(3'b011, ls_direct ? 3'b011 : 3'b010, 2'b00, 1'b1, 4'b0000, 1'b0));
        q.push_back(mk(3'b011, 3'b000, 2'b00, 1'b0, 4'b0000, 1'b1));
      end
      else if (load_req)  push_read(3'b010, ls_direct ? 3'b011 : 3'b010, 4'b0100);
      else if (fetch_req) push_read(3'b001, 3'b000, 4'b1000);
      if (q.size() > 0) cur <= q.pop_front();
      else              cur <= '0;
    end else begin
      cur <= '0;
    end
  end

  // ---------------- checking ----------------
  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_en = 1'b0;
  int  ir_cyc = -1;
  int  done_cnt = 0;

  task automatic chk(input string name, input int a, input int e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  // Advance one cycle and compare the main instance against the model.
  task automatic step();
    @(posedge clk);
    #2;
    if (chk_en) begin
      vectors++;
      if (act !== cur) begin
        miscompares++;
        $display("FAIL cycle_check cyc=%0d got=%h expected=%h", cyc, act, cur);
      end
    end
    if (ir_load === 1'b1) ir_cyc = cyc;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic wait_done(input logic [2:0] want, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done === 1'b1 && op === want) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout waiting done for op %0d: got none expected done", want);
    end
  endtask

  initial begin
    int t0, t1, d, d2, dc0, op10, op11, irc;
    repeat (2) step();
    chk_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_op", op, 0);
    chk("reset_iord", iord_sel, 0);
    reset = 1'b0;
    step();

    // single fetch
    step(); fetch_req = 1'b1; t0 = cyc;
    wait_done(3'b001, d); fetch_req = 1'b0;
    chk("fetch_ir_cycle", ir_cyc - t0, 2);
    chk("fetch_done_cycle", d - t0, 3);

    // exc + swap + fetch simultaneous
    step(); exc_req = 1'b1; swap_req = 1'b1; fetch_req = 1'b1; t0 = cyc;
    step();
    chk("prio_op", op, 5);
    chk("prio_iord", iord_sel, 1);
    wait_done(3'b101, d); exc_req = 1'b0;
    chk("prio_exc_done", d - t0, 3);
    wait_done(3'b100, d); swap_req = 1'b0;
    chk("prio_swap_done", d - t0, 11);
    wait_done(3'b001, d); fetch_req = 1'b0;
    chk("prio_fetch_done", d - t0, 15);

    // swap alone
    step(); swap_req = 1'b1; t0 = cyc;
    wait_done(3'b100, d); swap_req = 1'b0;
    chk("swap_done", d - t0, 7);

    // store direct, then load registered
    step(); store_req = 1'b1; ls_direct = 1'b1; t0 = cyc;
    step();
    chk("store_iord", iord_sel, 3);
    chk("store_wr", mem_wr, 1);
    wait_done(3'b011, d); store_req = 1'b0; ls_direct = 1'b0;
    chk("store_done", d - t0, 2);
    step(); load_req = 1'b1; t1 = cyc;
    step();
    chk("load_iord", iord_sel, 2);
    chk("load_wr", mem_wr, 0);
    wait_done(3'b010, d); load_req = 1'b0;
    chk("load_done", d - t1, 3);

    // swap aborted by reset during SW_WR1
    step(); swap_req = 1'b1; t0 = cyc; dc0 = done_cnt;
    repeat (5) step();
    chk("abort_wr_before", mem_wr, 1);
    reset = 1'b1; swap_req = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_wr_after", mem_wr, 0);
    reset = 1'b0; fetch_req = 1'b1; t1 = cyc;
    wait_done(3'b001, d); fetch_req = 1'b0;
    chk("abort_fetch_done", d - t1, 3);
    chk("abort_no_done", done_cnt - dc0, 1);

    // load raised while busy waits for the next IDLE
    step(); fetch_req = 1'b1; t0 = cyc;
    step(); load_req = 1'b1;
    wait_done(3'b001, d); fetch_req = 1'b0;
    chk("busy_fetch_done", d - t0, 3);
    wait_done(3'b010, d); load_req = 1'b0;
    chk("busy_load_done", d - t0, 7);

    // RD_WAIT = 0
    step(); f0 = 1'b1; t0 = cyc; d = -1; irc = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (w0_ir === 1'b1) irc = cyc;
      if (w0_done === 1'b1) begin d = cyc; break; end
    end
    f0 = 1'b0;
    chk("w0_ir_cycle", irc - t0, 1);
    chk("w0_done_cycle", d - t0, 2);

    // RD_WAIT = 7 with a load raised mid-read
    step(); f7 = 1'b1; t0 = cyc; d = -1; d2 = -1; op10 = -1; op11 = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (cyc == t0 + 3) l7 = 1'b1;
      if (cyc == t0 + 10) op10 = w7_op;
      if (cyc == t0 + 11) op11 = w7_op;
      if (w7_done === 1'b1 && w7_op === 3'b001) begin d = cyc; f7 = 1'b0; end
      if (w7_done === 1'b1 && w7_op === 3'b010) begin d2 = cyc; l7 = 1'b0; break; end
    end
    f7 = 1'b0; l7 = 1'b0;
    chk("w7_fetch_done", d - t0, 9);
    chk("w7_idle_op", op10, 0);
    chk("w7_load_granted", op11, 2);
    chk("w7_load_done", d2 - t0, 19);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
